// File: rtl/cache_pkg.sv
// Shared cache-side definitions: default line-decoder geometry, request bundle, output-register state.
package cache_pkg;

  localparam int DEF_NUM_OUT = 16;
  localparam int DEF_SEL_W   = 4;

  // Request bundle as presented by the cache controller.
  typedef struct packed {
    logic [DEF_SEL_W-1:0] idx;
    logic                 victim;
    logic                 enable;
  } sel_req_t;

  // Occupancy of the single output register.
  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } out_state_e;

endpackage

// File: rtl/rr_victim_ptr.sv
// Round-robin victim pointer: counts 0..NUM_OUT-1 and wraps, stepping once per adv.
module rr_victim_ptr #(
  parameter int NUM_OUT = 16,
  parameter int SEL_W   = $clog2(NUM_OUT)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             adv,
  output logic [SEL_W-1:0] ptr
);

  logic [SEL_W-1:0] ptr_q;

  // Pointer register; reset wins over a simultaneous advance.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else if (adv) begin
      if (ptr_q == SEL_W'(NUM_OUT - 1)) ptr_q <= '0;
      else                              ptr_q <= ptr_q + 1'b1;
    end
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/line_select_decoder.sv
// Registered index-to-one-hot decoder with valid/ready handshake and a round-robin victim mode.
//
// Handshake: a transfer happens on any rising edge where valid && ready.
// Upstream: in_ready = !out_valid || out_ready, so a held result can drain
// and be replaced in the same cycle. Downstream: out_* hold stable while
// out_valid && !out_ready. No combinational path from in_* to out_*.
module line_select_decoder
  import cache_pkg::*;
#(
  parameter int NUM_OUT = DEF_NUM_OUT,
  parameter int SEL_W   = $clog2(NUM_OUT)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [SEL_W-1:0]   in_idx,
  input  logic               in_victim,
  input  logic               in_enable,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [NUM_OUT-1:0] out_onehot,
  output logic [SEL_W-1:0]   out_idx,
  output logic               out_err
);

  // One-hot of idx; an index beyond the last line yields all zeros.
  function automatic logic [NUM_OUT-1:0] decode(input logic [SEL_W-1:0] idx);
    logic [NUM_OUT-1:0] res;
    res = '0;
    for (int i = 0; i < NUM_OUT; i++) begin
      res[i] = (int'(idx) == i);
    end
    return res;
  endfunction

  out_state_e         state_q;
  out_state_e         state_d;
  logic               accept;
  logic               drain;
  logic [SEL_W-1:0]   rr_ptr;
  logic [SEL_W-1:0]   eff_idx;
  logic               eff_err;
  logic [NUM_OUT-1:0] eff_onehot;

  assign out_valid = (state_q == ST_FULL);
  assign in_ready  = !out_valid || out_ready;
  assign accept    = in_valid && in_ready;
  assign drain     = out_valid && out_ready;

  // Only an accepted victim request consumes a victim slot (even when disabled).
  rr_victim_ptr #(
    .NUM_OUT (NUM_OUT),
    .SEL_W   (SEL_W)
  ) u_rr_ptr (
    .clk (clk),
    .rst (rst),
    .adv (accept && in_victim),
    .ptr (rr_ptr)
  );

  // Effective index, range error and decoded vector for the current request.
  always_comb begin
    eff_idx    = in_victim ? rr_ptr : in_idx;
    eff_err    = !in_victim && (int'(in_idx) >= NUM_OUT);
    eff_onehot = '0;
    if (in_enable && !eff_err) eff_onehot = decode(eff_idx);
  end

  // Output-register occupancy: fill on accept, empty on drain without refill.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_EMPTY: if (accept) state_d = ST_FULL;
      ST_FULL:  if (drain && !accept) state_d = ST_EMPTY;
      default:  state_d = ST_EMPTY;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_EMPTY;
    else     state_q <= state_d;
  end

  // Result register: loads on accept, otherwise holds.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_onehot <= '0;
      out_idx    <= '0;
      out_err    <= 1'b0;
    end else if (accept) begin
      out_onehot <= eff_onehot;
      out_idx    <= eff_idx;
      out_err    <= eff_err;
    end
  end

endmodule
